// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - program store and issue sequencer feeding one instruction per clock to the CPU; loop mode via SEQ_LOOP_EN
module instr_sequencer #(
    parameter int          DEPTH     = 16,
    parameter int          ADDR_W    = 4,
    parameter logic [20:0] NOP_INSTR = 21'h000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [20:0]       load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              start,
    input  logic              stop,
    input  logic              step,
    output logic [20:0]       instr_out,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W:0]   prog_len,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_STEP} state_e;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [20:0]       mem_q [DEPTH];
    logic [ADDR_W:0]   wp_q, wp_d;
    logic [ADDR_W:0]   prog_len_q, prog_len_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [20:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              load_fire;
    logic              pc_last;
    logic              run_start;
    logic [ADDR_W-1:0] pc_inc;

    // wp reaching DEPTH marks a full store; it is rewound on load_last or when a run starts
    assign load_ready = (state_q == S_IDLE) && !wp_q[ADDR_W];
    assign load_fire  = load_valid && load_ready;
    assign pc_last    = ({1'b0, pc_q} == (prog_len_q - 1'b1));
    assign run_start  = start && !load_fire && (prog_len_q != '0);
    assign pc_inc     = pc_q + 1'b1;

    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign prog_len    = prog_len_q;
    assign done        = done_q;
    assign busy        = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wp_q       <= '0;
            prog_len_q <= '0;
            pc_q       <= '0;
            instr_q    <= NOP_INSTR;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wp_q       <= wp_d;
            prog_len_q <= prog_len_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
        end
    end

    // Store contents survive reset by design
    always_ff @(posedge clk) begin
        if (rst && load_fire) begin
            mem_q[wp_q[ADDR_W-1:0]] <= load_data;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (run_start) state_d = S_RUN;
            S_RUN: begin
`ifdef SEQ_LOOP_EN
                if (stop) state_d = S_HALT;
`else
                if (pc_last)   state_d = S_IDLE;
                else if (stop) state_d = S_HALT;
`endif
            end
            S_HALT: begin
                if (stop)       state_d = S_HALT;
                else if (start) state_d = S_RUN;
                else if (step)  state_d = S_STEP;
            end
            S_STEP: begin
`ifdef SEQ_LOOP_EN
                state_d = S_HALT;
`else
                state_d = pc_last ? S_IDLE : S_HALT;
`endif
            end
        endcase
    end

    always_comb begin
        wp_d       = wp_q;
        prog_len_d = prog_len_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        done_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (load_fire) begin
                    prog_len_d = wp_q + 1'b1;
                    if (load_last)                 wp_d = '0;
                    else if (wp_q == DEPTH_L - 1'b1) wp_d = DEPTH_L;
                    else                           wp_d = wp_q + 1'b1;
                end else if (run_start) begin
                    wp_d    = '0;
                    pc_d    = '0;
                    instr_d = mem_q[0];
                    valid_d = 1'b1;
                end
            end
            S_RUN: begin
`ifdef SEQ_LOOP_EN
                if (stop) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    pc_d    = pc_last ? '0 : pc_inc;
                end else if (pc_last) begin
                    instr_d = mem_q[0];
                    pc_d    = '0;
                    done_d  = 1'b1;
                end else begin
                    pc_d    = pc_inc;
                    instr_d = mem_q[pc_inc];
                end
`else
                if (pc_last) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    pc_d    = '0;
                    done_d  = 1'b1;
                end else if (stop) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    pc_d    = pc_inc;
                end else begin
                    pc_d    = pc_inc;
                    instr_d = mem_q[pc_inc];
                end
`endif
            end
            S_HALT: begin
                if (!stop && (start || step)) begin
                    instr_d = mem_q[pc_q];
                    valid_d = 1'b1;
                end
            end
            S_STEP: begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
                if (pc_last) begin
                    pc_d   = '0;
                    done_d = 1'b1;
                end else begin
                    pc_d   = pc_inc;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer; loop scenario built with SEQ_LOOP_EN
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic [20:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        start;
    logic        stop;
    logic        step;
    logic [20:0] instr_out;
    logic        instr_valid;
    logic [3:0]  pc;
    logic [4:0]  prog_len;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    localparam logic [20:0] A = 21'h1A2B3C;
    localparam logic [20:0] B = 21'h0F0F0F;
    localparam logic [20:0] C = 21'h155555;

    logic [20:0] d [5];

    instr_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .start      (start),
        .stop       (stop),
        .step       (step),
        .instr_out  (instr_out),
        .instr_valid(instr_valid),
        .pc         (pc),
        .prog_len   (prog_len),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_word(input logic [20:0] w, input logic last);
        load_valid = 1'b1;
        load_data  = w;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        start = 1'b0; stop = 1'b0; step = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        chk("rst_instr", instr_out, 21'h0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_pc", pc, 0);
        chk("rst_len", prog_len, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", load_ready, 1);

        // Full store without load_last, then reset mid-run
        for (int i = 0; i < 16; i++) load_word(21'(i * 21'h1111 + 5), 1'b0);
        chk("full_ready", load_ready, 0);
        chk("full_len", prog_len, 16);
        load_word(21'h1FFFFF, 1'b0);
        chk("full_17_len", prog_len, 16);
        chk("full_17_ready", load_ready, 0);
        pulse_start();
        chk("full_run_w0", instr_out, 21'h5);
        chk("full_run_v", instr_valid, 1);
        tick();
        tick();
        chk("full_run_pc2", pc, 2);
        chk("full_run_w2", instr_out, 21'h2227);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_rst_valid", instr_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_len", prog_len, 0);
        chk("mid_rst_pc", pc, 0);
        chk("mid_rst_instr", instr_out, 21'h0);
        pulse_start();
        chk("start_empty_busy", busy, 0);
        chk("start_empty_valid", instr_valid, 0);

`ifdef SEQ_LOOP_EN
        load_word(A, 1'b0);
        load_word(B, 1'b1);
        pulse_start();
        chk("loop_a0", instr_out, A);
        chk("loop_a0_done", done, 0);
        tick();
        chk("loop_b0", instr_out, B);
        tick();
        chk("loop_a1", instr_out, A);
        chk("loop_a1_valid", instr_valid, 1);
        chk("loop_a1_done", done, 1);
        chk("loop_a1_pc", pc, 0);
        tick();
        chk("loop_b1", instr_out, B);
        chk("loop_b1_done", done, 0);
        tick();
        chk("loop_a2_done", done, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("loop_halt_valid", instr_valid, 0);
        chk("loop_halt_busy", busy, 1);
        chk("loop_halt_pc", pc, 1);
`else
        // Three-word run to completion
        load_word(A, 1'b0);
        load_word(B, 1'b0);
        load_word(C, 1'b1);
        chk("abc_len", prog_len, 3);
        pulse_start();
        chk("abc_a", instr_out, A);
        chk("abc_a_v", instr_valid, 1);
        chk("abc_a_pc", pc, 0);
        chk("abc_busy", busy, 1);
        chk("abc_ready", load_ready, 0);
        tick();
        chk("abc_b", instr_out, B);
        chk("abc_b_pc", pc, 1);
        tick();
        chk("abc_c", instr_out, C);
        chk("abc_c_pc", pc, 2);
        chk("abc_c_v", instr_valid, 1);
        tick();
        chk("abc_done", done, 1);
        chk("abc_end_v", instr_valid, 0);
        chk("abc_end_busy", busy, 0);
        chk("abc_end_instr", instr_out, 21'h0);
        chk("abc_end_len", prog_len, 3);
        tick();
        chk("abc_done_clr", done, 0);

        // Stop, step, resume on a five-word program
        for (int i = 0; i < 5; i++) d[i] = 21'(21'h10000 + i * 21'h101);
        for (int i = 0; i < 5; i++) load_word(d[i], i == 4);
        chk("five_len", prog_len, 5);
        pulse_start();
        tick();
        chk("five_pc1", pc, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("halt_valid", instr_valid, 0);
        chk("halt_pc", pc, 2);
        chk("halt_busy", busy, 1);
        tick();
        chk("halt_hold_pc", pc, 2);
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("step_instr", instr_out, d[2]);
        chk("step_valid", instr_valid, 1);
        chk("step_pc", pc, 2);
        tick();
        chk("step_after_v", instr_valid, 0);
        chk("step_after_pc", pc, 3);
        pulse_start();
        chk("resume_d3", instr_out, d[3]);
        chk("resume_v", instr_valid, 1);
        tick();
        chk("resume_d4", instr_out, d[4]);
        tick();
        chk("resume_done", done, 1);
        chk("resume_idle", busy, 0);

        // Stop on the last instruction still terminates
        pulse_start();
        tick(); tick(); tick(); tick();
        chk("last_pc4", pc, 4);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("last_stop_done", done, 1);
        chk("last_stop_busy", busy, 0);

        // start and stop together in HALT
        pulse_start();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("hs_pc", pc, 1);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("hs_valid", instr_valid, 0);
        chk("hs_busy", busy, 1);
        chk("hs_ready", load_ready, 0);
        tick();
        chk("hs_hold_v", instr_valid, 0);

        // Load beats start in the same IDLE cycle
        rst = 1'b0;
        tick();
        rst = 1'b1;
        load_word(A, 1'b1);
        start = 1'b1;
        load_valid = 1'b1; load_data = B; load_last = 1'b1;
        tick();
        start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        chk("ls_busy", busy, 0);
        chk("ls_valid", instr_valid, 0);
        pulse_start();
        chk("ls_overwrite", instr_out, B);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
